sensor_boot_seq: RTL

- Sits directly downstream of the reset generator in the boot_timing path.
- Consumes the generator's synchronous, stretched, active-low reset-release. Once released, drives the camera sensor power-up sequence: AVDD rail, DVDD rail, MCLK, sensor reset release, then configuration start.
- Waits for the configuration engine's done handshake with a watchdog.
- Reports boot done or boot error to the rest of the design.

---
 rtl/sensor_boot_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sensor_boot_seq.sv
// sensor_boot_seq: camera sensor power-up sequencer.
// After the reset generator releases, it brings up AVDD, DVDD and MCLK, releases
// the sensor reset, pulses config start, and then waits for config done under a
// watchdog. It reports boot done or boot error.
// Optional build macro: SENSOR_BOOT_RETRY_EN. When defined, a watchdog timeout
// power-cycles the sensor (S_OFF) up to MAX_RETRY times before it declares an error.
module sensor_boot_seq #(
   parameter int T_PWR1    = 1000,
   parameter int T_PWR2    = 1000,
   parameter int T_MCLK    = 200,
   parameter int T_RST     = 5000,
   parameter int T_CFG_TO  = 1000000,
   parameter int CNT_W     = 20,
   parameter int MAX_RETRY = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sys_rst_n,
   input  logic       i_cfg_done,
   output logic       o_avdd_en,
   output logic       o_dvdd_en,
   output logic       o_mclk_en,
   output logic       o_sensor_rst_n,
   output logic       o_cfg_start,
   output logic       o_boot_done,
   output logic       o_boot_err,
   output logic [2:0] o_state
);

   // Bit 3 of the state exists only so that S_OFF can be told apart internally.
   // o_state shows the low three bits, so S_OFF reads as 0.
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_AVDD = 4'd1;
   localparam logic [3:0] S_DVDD = 4'd2;
   localparam logic [3:0] S_MCLK = 4'd3;
   localparam logic [3:0] S_RST  = 4'd4;
   localparam logic [3:0] S_CFG  = 4'd5;
   localparam logic [3:0] S_DONE = 4'd6;
   localparam logic [3:0] S_ERR  = 4'd7;
`ifdef SENSOR_BOOT_RETRY_EN
   localparam logic [3:0] S_OFF  = 4'd8;
`endif

   localparam logic [CNT_W-1:0] PWR1_END = CNT_W'(T_PWR1 - 1);
   localparam logic [CNT_W-1:0] PWR2_END = CNT_W'(T_PWR2 - 1);
   localparam logic [CNT_W-1:0] MCLK_END = CNT_W'(T_MCLK - 1);
   localparam logic [CNT_W-1:0] RST_END  = CNT_W'(T_RST - 1);
   localparam logic [CNT_W-1:0] CFG_END  = CNT_W'(T_CFG_TO - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] tm_q, tm_d;
   logic             cfg_start_d;

`ifdef SENSOR_BOOT_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   logic [RW-1:0] retry_q, retry_d;
`else
   // Without retry, MAX_RETRY has no role in the logic.
   logic unused_max_retry;
   assign unused_max_retry = ^MAX_RETRY;
`endif

   // Next-state, timer and config-start decode. Each exit compare happens before the increment.
   always_comb begin
      state_d     = state_q;
      tm_d        = (tm_q == CNT_MAX) ? tm_q : tm_q + 1'b1;
      cfg_start_d = 1'b0;
`ifdef SENSOR_BOOT_RETRY_EN
      retry_d     = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            tm_d = '0;
            if (i_sys_rst_n) state_d = S_AVDD;
         end
         S_AVDD: if (tm_q == PWR1_END) state_d = S_DVDD;
         S_DVDD: if (tm_q == PWR2_END) state_d = S_MCLK;
         S_MCLK: if (tm_q == MCLK_END) state_d = S_RST;
         S_RST: begin
            if (tm_q == RST_END) begin
               state_d     = S_CFG;
               cfg_start_d = 1'b1;
            end
         end
         S_CFG: begin
            // If done and timeout arrive on the same cycle, done takes priority.
            if (i_cfg_done) begin
               state_d = S_DONE;
            end else if (tm_q == CFG_END) begin
`ifdef SENSOR_BOOT_RETRY_EN
               state_d = (retry_q < RETRY_LIM) ? S_OFF : S_ERR;
`else
               state_d = S_ERR;
`endif
            end
         end
`ifdef SENSOR_BOOT_RETRY_EN
         S_OFF: begin
            if (tm_q == PWR1_END) begin
               state_d = S_AVDD;
               retry_d = retry_q + 1'b1;
            end
         end
`endif
         S_DONE, S_ERR: tm_d = '0;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) tm_d = '0;

      // A dropped release aborts the sequence from any state except idle.
      if (!i_sys_rst_n && state_q != S_IDLE) begin
         state_d     = S_IDLE;
         tm_d        = '0;
         cfg_start_d = 1'b0;
`ifdef SENSOR_BOOT_RETRY_EN
         retry_d     = '0;
`endif
      end
   end

   // State, timer and retry registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         tm_q    <= '0;
`ifdef SENSOR_BOOT_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         tm_q    <= tm_d;
`ifdef SENSOR_BOOT_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   // Outputs are decoded from the next state and registered, so each one changes on the transition edge.
   // S_OFF (8) lies outside every range below, so all outputs are driven low in S_OFF.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_avdd_en      <= 1'b0;
         o_dvdd_en      <= 1'b0;
         o_mclk_en      <= 1'b0;
         o_sensor_rst_n <= 1'b0;
         o_cfg_start    <= 1'b0;
         o_boot_done    <= 1'b0;
         o_boot_err     <= 1'b0;
      end else begin
         o_avdd_en      <= (state_d >= S_AVDD) && (state_d <= S_DONE);
         o_dvdd_en      <= (state_d >= S_DVDD) && (state_d <= S_DONE);
         o_mclk_en      <= (state_d >= S_MCLK) && (state_d <= S_DONE);
         o_sensor_rst_n <= (state_d >= S_RST)  && (state_d <= S_DONE);
         o_cfg_start    <= cfg_start_d;
         o_boot_done    <= (state_d == S_DONE);
         o_boot_err     <= (state_d == S_ERR);
      end
   end

   assign o_state = state_q[2:0];

endmodule
